// File: rtl/snow64_denormalizer_pkg.sv
// Shared constants and FSM state type for the Snow64 iterative denormalizer.
// Widths match the 64-bit leading-zero counters: 64-bit data, 7-bit count.
package snow64_denormalizer_pkg;

  localparam int WIDTH      = 64;
  localparam int CNT_WIDTH  = 7;
  localparam int NUM_STAGES = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/snow64_denorm_shift_stage.sv
// One conditional right shift by 2^k; reports the top discarded bit and the
// OR of the discarded bits below it.
module snow64_denorm_shift_stage #(
  parameter int WIDTH = 64,
  parameter int SEL_W = 3
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [SEL_W-1:0] i_k,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_data,
  output logic             o_disc_top,
  output logic             o_disc_low
);

  localparam int AMT_W = $clog2(WIDTH) + 1;

  logic [AMT_W-1:0] w_amt;
  logic [WIDTH-1:0] w_top_mask;
  logic [WIDTH-1:0] w_low_mask;

  assign w_amt      = AMT_W'(1) << i_k;
  assign w_top_mask = WIDTH'(1) << (w_amt - AMT_W'(1));
  assign w_low_mask = w_top_mask - WIDTH'(1);

  always_comb begin
    o_data     = i_data;
    o_disc_top = 1'b0;
    o_disc_low = 1'b0;
    if (i_en) begin
      o_data     = i_data >> w_amt;
      o_disc_top = |(i_data & w_top_mask);
      o_disc_low = |(i_data & w_low_mask);
    end
  end

endmodule

// File: rtl/snow64_iterative_denormalizer.sv
// Multi-cycle right shifter (one binary stage per cycle, 32 down to 1) with sticky.
// Optional round-to-nearest-even via SNOW64_ITERATIVE_DENORMALIZER_ROUND_EN.
module snow64_iterative_denormalizer
  import snow64_denormalizer_pkg::*;
#(
  parameter int WIDTH     = snow64_denormalizer_pkg::WIDTH,
  parameter int CNT_WIDTH = snow64_denormalizer_pkg::CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [CNT_WIDTH-1:0] in_count,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_sticky,
  output state_t               dbg_state
);

  localparam int NUM_STAGES = $clog2(WIDTH);
  localparam int SEL_W      = $clog2(NUM_STAGES);

  // Handshake: a transfer happens on a rising clk edge where valid && ready;
  // valid holds its payload stable until that edge, ready never waits on valid.

  state_t                r_state, w_state_nxt;
  logic [SEL_W-1:0]      r_stage_idx, w_stage_nxt;
  logic [WIDTH-1:0]      r_data, w_data_nxt;
  logic [NUM_STAGES-1:0] r_count, w_count_nxt;
  logic                  r_sticky, w_sticky_nxt;
`ifdef SNOW64_ITERATIVE_DENORMALIZER_ROUND_EN
  logic                  r_guard, w_guard_nxt;
`endif

  logic             w_sh_en;
  logic [WIDTH-1:0] w_sh_data;
  logic             w_sh_top;
  logic             w_sh_low;

  assign w_sh_en = (r_state == SHIFT) &&
                   (|(r_count & (NUM_STAGES'(1) << r_stage_idx)));

  snow64_denorm_shift_stage #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_stage (
    .i_data     (r_data),
    .i_k        (r_stage_idx),
    .i_en       (w_sh_en),
    .o_data     (w_sh_data),
    .o_disc_top (w_sh_top),
    .o_disc_low (w_sh_low)
  );

  assign in_ready   = (r_state == IDLE) && !rst;
  assign out_valid  = (r_state == DONE);
  assign out_data   = r_data;
  assign out_sticky = r_sticky;
  assign dbg_state  = r_state;

  always_comb begin
    w_state_nxt  = r_state;
    w_stage_nxt  = r_stage_idx;
    w_data_nxt   = r_data;
    w_count_nxt  = r_count;
    w_sticky_nxt = r_sticky;
`ifdef SNOW64_ITERATIVE_DENORMALIZER_ROUND_EN
    w_guard_nxt  = r_guard;
`endif
    case (r_state)
      IDLE: begin
        if (in_valid && in_ready) begin
          w_state_nxt = SHIFT;
          w_stage_nxt = SEL_W'(NUM_STAGES - 1);
`ifdef SNOW64_ITERATIVE_DENORMALIZER_ROUND_EN
          w_guard_nxt = 1'b0;
`endif
          if (in_count >= CNT_WIDTH'(WIDTH)) begin
            // Everything is shifted out; later stages see a zero count.
            w_data_nxt   = '0;
            w_count_nxt  = '0;
            w_sticky_nxt = |in_data;
`ifdef SNOW64_ITERATIVE_DENORMALIZER_ROUND_EN
            if (in_count == CNT_WIDTH'(WIDTH)) begin
              w_guard_nxt  = in_data[WIDTH-1];
              w_sticky_nxt = |in_data[WIDTH-2:0];
            end
`endif
          end else begin
            w_data_nxt   = in_data;
            w_count_nxt  = in_count[NUM_STAGES-1:0];
            w_sticky_nxt = 1'b0;
          end
        end
      end
      SHIFT: begin
        w_data_nxt = w_sh_data;
`ifdef SNOW64_ITERATIVE_DENORMALIZER_ROUND_EN
        // Larger stages run first, so each newly discarded top bit outranks
        // the old guard, which then drops into sticky.
        if (w_sh_en) begin
          w_guard_nxt  = w_sh_top;
          w_sticky_nxt = r_sticky | r_guard | w_sh_low;
        end
`else
        w_sticky_nxt = r_sticky | w_sh_top | w_sh_low;
`endif
        if (r_stage_idx == '0) begin
`ifdef SNOW64_ITERATIVE_DENORMALIZER_ROUND_EN
          w_state_nxt = ROUND;
`else
          w_state_nxt = DONE;
`endif
        end else begin
          w_stage_nxt = r_stage_idx - SEL_W'(1);
        end
      end
`ifdef SNOW64_ITERATIVE_DENORMALIZER_ROUND_EN
      ROUND: begin
        w_data_nxt  = r_data + WIDTH'(r_guard & (r_sticky | r_data[0]));
        w_state_nxt = DONE;
      end
`endif
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_stage_idx <= '0;
      r_data      <= '0;
      r_count     <= '0;
      r_sticky    <= 1'b0;
`ifdef SNOW64_ITERATIVE_DENORMALIZER_ROUND_EN
      r_guard     <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_stage_idx <= w_stage_nxt;
      r_data      <= w_data_nxt;
      r_count     <= w_count_nxt;
      r_sticky    <= w_sticky_nxt;
`ifdef SNOW64_ITERATIVE_DENORMALIZER_ROUND_EN
      r_guard     <= w_guard_nxt;
`endif
    end
  end

endmodule
